// File: rtl/wt_cache_pkg.sv
// Shared types, L1.5 size encodings and chunk-selection helpers for the
// write-through dcache store path.
//   - L15_TID_WIDTH         : transaction id width on the L1.5 interface
//   - L15_SIZE_*            : log2(bytes) size encodings used on the NoC
//   - split_state_e         : store splitter FSM states
//   - chunkSel()            : scalar reference of the chunk selection rule
//   - toSize32/toSize64     : legacy single-shot byte-enable to size mapping
package wt_cache_pkg;

  localparam int unsigned L15_TID_WIDTH = 2;

  localparam logic [2:0] L15_SIZE_BYTE  = 3'b000;
  localparam logic [2:0] L15_SIZE_HWORD = 3'b001;
  localparam logic [2:0] L15_SIZE_WORD  = 3'b010;
  localparam logic [2:0] L15_SIZE_DWORD = 3'b011;

  // Widest supported store is 512 bits -> 64 byte lanes.
  localparam int unsigned CHUNK_MAX_NB = 64;

  typedef enum logic {
    ST_IDLE,
    ST_SPLIT
  } split_state_e;

  typedef struct packed {
    logic [5:0]              offset;
    logic [2:0]              size;
    logic [CHUNK_MAX_NB-1:0] mask;
  } chunk_sel_t;

  // Picks the chunk starting at the lowest set bit of rem: the largest
  // naturally aligned, fully populated power-of-two run not wider than
  // 2**max_log2 bytes. Alignment and population both shrink monotonically
  // with size, so the last fitting size in an ascending scan is the largest.
  function automatic chunk_sel_t chunkSel(input logic [CHUNK_MAX_NB-1:0] rem,
                                          input int unsigned max_log2);
    chunk_sel_t              res;
    logic [CHUNK_MAX_NB-1:0] run;
    res = '0;
    for (int i = int'(CHUNK_MAX_NB) - 1; i >= 0; i--) begin
      if (rem[i]) res.offset = 6'(i);
    end
    for (int s = 0; s <= 6; s++) begin
      run = ~({CHUNK_MAX_NB{1'b1}} << (1 << s));
      if ((s <= int'(max_log2)) && ((int'(res.offset) % (1 << s)) == 0) &&
          (((rem >> res.offset) & run) == run)) begin
        res.size = 3'(s);
      end
    end
    run      = ~({CHUNK_MAX_NB{1'b1}} << (1 << res.size));
    res.mask = (run << res.offset) & rem;
    return res;
  endfunction

  function automatic logic [2:0] toSize32(input logic [3:0] be);
    logic [2:0] size;
    case (be)
      4'b1111:          size = L15_SIZE_WORD;
      4'b1100, 4'b0011: size = L15_SIZE_HWORD;
      default:          size = L15_SIZE_BYTE;
    endcase
    return size;
  endfunction

  function automatic logic [2:0] toSize64(input logic [7:0] be);
    logic [2:0] size;
    case (be)
      8'hff:                         size = L15_SIZE_DWORD;
      8'h0f, 8'hf0:                  size = L15_SIZE_WORD;
      8'hc0, 8'h30, 8'h0c, 8'h03:    size = L15_SIZE_HWORD;
      default:                       size = L15_SIZE_BYTE;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/wt_chunk_sel.sv
// Combinational chunk selector.
// Given the remaining byte-enable mask of a store, returns the next chunk to
// emit: the lowest set lane, the largest legal power-of-two size at that lane
// (capped at 2**MAX_SIZE_LOG2 bytes), the chunk's lane mask, and whether it
// exhausts the mask.
//   rem_i  : remaining byte enables
//   off_o  : lane offset of the chunk
//   size_o : log2(chunk bytes)
//   mask_o : lanes covered by the chunk (zero when rem_i is zero)
//   last_o : no lanes remain after this chunk
module wt_chunk_sel
  import wt_cache_pkg::*;
#(
  parameter  int unsigned NB            = 8,
  parameter  int unsigned MAX_SIZE_LOG2 = 3,
  localparam int unsigned OW            = $clog2(NB)
) (
  input  logic [NB-1:0] rem_i,
  output logic [OW-1:0] off_o,
  output logic [2:0]    size_o,
  output logic [NB-1:0] mask_o,
  output logic          last_o
);

  logic [NB-1:0]          rem_shift;
  logic [MAX_SIZE_LOG2:0] fit;
  logic [NB-1:0]          run;

  // Trailing-zero count: the lowest set lane wins.
  always_comb begin
    off_o = '0;
    for (int i = int'(NB) - 1; i >= 0; i--) begin
      if (rem_i[i]) off_o = OW'(i);
    end
  end

  assign rem_shift = rem_i >> off_o;

  // One candidate per size: the offset must be aligned to the size and all
  // lanes of the run must still be pending.
  for (genvar gi = 0; gi <= int'(MAX_SIZE_LOG2); gi++) begin : g_fit
    localparam int unsigned RUN          = 1 << gi;
    localparam logic [NB-1:0] RUN_MASK   = ~({NB{1'b1}} << RUN);
    assign fit[gi] = ((off_o & OW'(RUN - 1)) == '0) &&
                     ((rem_shift & RUN_MASK) == RUN_MASK);
  end

  always_comb begin
    size_o = L15_SIZE_BYTE;
    for (int s = 0; s <= int'(MAX_SIZE_LOG2); s++) begin
      if (fit[s]) size_o = 3'(s);
    end
  end

  // A shift by the full width yields zero, so a full-width run comes out as
  // all ones without needing an extra guard bit.
  assign run    = ~({NB{1'b1}} << (1 << size_o));
  assign mask_o = (run << off_o) & rem_i;
  assign last_o = ((rem_i & ~mask_o) == '0);

endmodule

// File: rtl/wt_store_splitter.sv
// Store splitter between the write buffer and the L1.5 request FIFO.
// Accepts one store (data word + arbitrary byte enables) and emits it as a
// sequence of naturally aligned power-of-two chunks, one per handshake, in
// ascending address order.
//   clk_i / rst_i          : clock, synchronous active-high reset
//   req_valid_i/ready_o    : store request handshake
//   req_addr_i/data_i/be_i/tid_i : store payload (address lane bits ignored)
//   out_valid_o/ready_i    : chunk handshake
//   out_addr_o/size_o/be_o : chunk address, log2 size and lane mask
//   out_data_o/tid_o       : held store data (unshifted) and id
//   out_last_o             : final chunk of the store
module wt_store_splitter
  import wt_cache_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH    = 64,
  parameter  int unsigned ADDR_WIDTH    = 64,
  parameter  int unsigned TID_WIDTH     = L15_TID_WIDTH,
  parameter  int unsigned MAX_SIZE_LOG2 = 3,
  localparam int unsigned NB            = DATA_WIDTH / 8,
  localparam int unsigned OW            = $clog2(NB)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic [NB-1:0]         req_be_i,
  input  logic [TID_WIDTH-1:0]  req_tid_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic [2:0]            out_size_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [NB-1:0]         out_be_o,
  output logic [TID_WIDTH-1:0]  out_tid_o,
  output logic                  out_last_o
);

  split_state_e           state_q, state_d;
  logic [ADDR_WIDTH-OW-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [NB-1:0]          rem_q, rem_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;

  logic [OW-1:0] sel_off;
  logic [2:0]    sel_size;
  logic [NB-1:0] sel_mask;
  logic          sel_last;

  logic fire;
  logic accept;

  // Lane bits of the store address are ignored; the chunk offset replaces them.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^req_addr_i[OW-1:0];

  wt_chunk_sel #(
    .NB            (NB),
    .MAX_SIZE_LOG2 (MAX_SIZE_LOG2)
  ) u_chunk_sel (
    .rem_i  (rem_q),
    .off_o  (sel_off),
    .size_o (sel_size),
    .mask_o (sel_mask),
    .last_o (sel_last)
  );

  // State and holding register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      tid_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      tid_q   <= tid_d;
    end
  end

  assign fire   = out_valid_o & out_ready_i;
  assign accept = req_valid_i & req_ready_o;

  // Next state. An accept on the last-chunk handshake chains straight into
  // the next store; an all-zero mask has nothing to emit.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = (req_be_i != '0) ? ST_SPLIT : ST_IDLE;
    end else if (fire && out_last_o) begin
      state_d = ST_IDLE;
    end
  end

  // Holding register update. Fields other than rem only change on accept, so
  // the outputs stay stable across a stall.
  always_comb begin
    base_d = base_q;
    data_d = data_q;
    rem_d  = rem_q;
    tid_d  = tid_q;
    if (accept) begin
      base_d = req_addr_i[ADDR_WIDTH-1:OW];
      data_d = req_data_i;
      rem_d  = req_be_i;
      tid_d  = req_tid_i;
    end else if (fire) begin
      rem_d = rem_q & ~sel_mask;
    end
  end

  // Outputs.
  always_comb begin
    out_valid_o = (state_q == ST_SPLIT);
    out_addr_o  = {base_q, sel_off};
    out_size_o  = sel_size;
    out_be_o    = sel_mask;
    out_data_o  = data_q;
    out_tid_o   = tid_q;
    out_last_o  = out_valid_o & sel_last;
    req_ready_o = (state_q == ST_IDLE) | (out_valid_o & out_ready_i & out_last_o);
  end

  // Chunk legality checks.
  logic [NB-1:0] be_norm;
  assign be_norm = out_be_o >> sel_off;

  a_be_nonzero: assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_o |-> (out_be_o != '0));

  a_size_cap: assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_o |-> (out_size_o <= 3'(MAX_SIZE_LOG2)));

  a_aligned_run: assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_o |-> ((be_norm == ~({NB{1'b1}} << (1 << out_size_o))) &&
                     ((int'(sel_off) & ((1 << out_size_o) - 1)) == 0)));

  a_width_pow2: assert property (@(posedge clk_i)
    (DATA_WIDTH & (DATA_WIDTH - 1)) == 0);

endmodule
